// File: rtl/inst_prefetch.sv
// Instruction prefetch queue: fetches 16-bit words ahead of the decoder into a small FIFO.
// Optional PREFETCH_ADDR_CHK_EN adds odd-redirect detection with a HALT state and addr_err.
module inst_prefetch #(
    parameter int unsigned DEPTH    = 3,
    parameter logic [23:0] RESET_PC = 24'h000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [23:0] flush_pc,
    output logic        bus_req,
    output logic [23:0] bus_addr,
    input  logic        bus_ack,
    input  logic [15:0] bus_data,
    output logic [15:0] inst,
    output logic [23:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic        addr_err
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] DepthC  = CntW'(DEPTH);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

`ifdef PREFETCH_ADDR_CHK_EN
    typedef enum logic [1:0] {StIdle, StReq, StHalt} state_e;
`else
    typedef enum logic [0:0] {StIdle, StReq} state_e;
`endif

    state_e            state_q, state_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [23:0]       fetch_pc_q, fetch_pc_d;
    logic [15:0]       data_q [DEPTH];
    logic [23:0]       pc_q   [DEPTH];
    logic              push, pop;
    logic [23:0]       flush_pc_even;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + PtrW'(1);
    endfunction

    assign flush_pc_even = {flush_pc[23:1], 1'b0};

    // Flush overrides both the bus handshake and the decoder handshake.
    assign push = (state_q == StReq) && bus_ack && !flush && (count_q < DepthC);
    assign pop  = inst_valid && inst_ready && !flush;

    // Queue bookkeeping and fetch address
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        fetch_pc_d = fetch_pc_q;
        if (flush) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            fetch_pc_d = flush_pc_even;
        end else begin
            if (push) begin
                wr_ptr_d   = ptr_inc(wr_ptr_q);
                fetch_pc_d = fetch_pc_q + 24'd2;
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                count_d = count_q + CntW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            fetch_pc_q <= RESET_PC;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i] <= 16'h0000;
                pc_q[i]   <= RESET_PC;
            end
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            fetch_pc_q <= fetch_pc_d;
            if (push) begin
                data_q[wr_ptr_q] <= bus_data;
                pc_q[wr_ptr_q]   <= fetch_pc_q;
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (flush) begin
`ifdef PREFETCH_ADDR_CHK_EN
            state_d = flush_pc[0] ? StHalt : StReq;
`else
            state_d = StReq;
`endif
        end else begin
            unique case (state_q)
                StIdle: if (count_q < DepthC) state_d = StReq;
                // count_d already reflects this cycle's push and pop
                StReq:  if (bus_ack) state_d = (count_d < DepthC) ? StReq : StIdle;
`ifdef PREFETCH_ADDR_CHK_EN
                StHalt: state_d = StHalt;
`endif
                default: state_d = StIdle;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        bus_req    = (state_q == StReq);
        bus_addr   = fetch_pc_q;
        inst_valid = (count_q != '0);
        inst       = data_q[rd_ptr_q];
        inst_pc    = pc_q[rd_ptr_q];
    end

`ifdef PREFETCH_ADDR_CHK_EN
    logic addr_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_err_q <= 1'b0;
        end else if (flush) begin
            addr_err_q <= flush_pc[0];
        end
    end

    assign addr_err = addr_err_q;
`else
    logic unused_flush_pc0;

    assign unused_flush_pc0 = flush_pc[0];
    assign addr_err         = 1'b0;
`endif

endmodule

// File: tb/tb_inst_prefetch.sv
// Self-checking bench for inst_prefetch: directed vector table plus hand-written
// sequences for streaming, mid-operation reset and odd redirect targets.
module tb_inst_prefetch;

    localparam logic [23:0] RstPc = 24'h000000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [23:0] flush_pc;
    logic        bus_req;
    logic [23:0] bus_addr;
    logic        bus_ack;
    logic [15:0] bus_data;
    logic [15:0] inst;
    logic [23:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        addr_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    inst_prefetch #(
        .DEPTH    (3),
        .RESET_PC (RstPc)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .bus_req    (bus_req),
        .bus_addr   (bus_addr),
        .bus_ack    (bus_ack),
        .bus_data   (bus_data),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .addr_err   (addr_err)
    );

    typedef struct {
        logic        fl;
        logic [23:0] fpc;
        logic        ack;
        logic [15:0] data;
        logic        rdy;
        logic        req;
        logic [23:0] addr;
        logic        vld;
        logic [15:0] ins;
        logic [23:0] ipc;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string nm);
        chk(nm, {bus_req, bus_addr, inst_valid, inst, inst_pc, addr_err},
            {1'b0, RstPc, 1'b0, 16'h0000, RstPc, 1'b0});
    endtask

    int          pops;
    logic [23:0] exp_pc;

    initial begin
        // Outputs are checked at the falling edge, before that row's inputs are driven.
        //           fl    fpc        ack   data      rdy   req   addr       vld   inst      ipc
        tbl[0]  = '{1'b0, 24'h000000, 1'b0, 16'h0000, 1'b0, 1'b0, 24'h000000, 1'b0, 16'h0000, 24'h000000};
        tbl[1]  = '{1'b0, 24'h000000, 1'b1, 16'h0000, 1'b0, 1'b1, 24'h000000, 1'b0, 16'h0000, 24'h000000};
        tbl[2]  = '{1'b0, 24'h000000, 1'b1, 16'h0002, 1'b0, 1'b1, 24'h000002, 1'b1, 16'h0000, 24'h000000};
        tbl[3]  = '{1'b0, 24'h000000, 1'b1, 16'h0004, 1'b0, 1'b1, 24'h000004, 1'b1, 16'h0000, 24'h000000};
        tbl[4]  = '{1'b0, 24'h000000, 1'b0, 16'h0000, 1'b0, 1'b0, 24'h000006, 1'b1, 16'h0000, 24'h000000};
        tbl[5]  = '{1'b0, 24'h000000, 1'b0, 16'h0000, 1'b1, 1'b0, 24'h000006, 1'b1, 16'h0000, 24'h000000};
        tbl[6]  = '{1'b0, 24'h000000, 1'b0, 16'h0000, 1'b1, 1'b0, 24'h000006, 1'b1, 16'h0002, 24'h000002};
        tbl[7]  = '{1'b0, 24'h000000, 1'b1, 16'h0006, 1'b1, 1'b1, 24'h000006, 1'b1, 16'h0004, 24'h000004};
        tbl[8]  = '{1'b0, 24'h000000, 1'b1, 16'h0008, 1'b0, 1'b1, 24'h000008, 1'b1, 16'h0006, 24'h000006};
        tbl[9]  = '{1'b1, 24'h001000, 1'b1, 16'h000a, 1'b1, 1'b1, 24'h00000a, 1'b1, 16'h0006, 24'h000006};
        tbl[10] = '{1'b0, 24'h000000, 1'b1, 16'hbeef, 1'b1, 1'b1, 24'h001000, 1'b0, 16'h0000, 24'h000000};
        tbl[11] = '{1'b0, 24'h000000, 1'b0, 16'h0000, 1'b1, 1'b1, 24'h001002, 1'b1, 16'hbeef, 24'h001000};
        tbl[12] = '{1'b1, 24'hfffffe, 1'b0, 16'h0000, 1'b0, 1'b1, 24'h001002, 1'b0, 16'h0000, 24'h000000};
        tbl[13] = '{1'b0, 24'h000000, 1'b1, 16'h1234, 1'b0, 1'b1, 24'hfffffe, 1'b0, 16'h0000, 24'h000000};
        tbl[14] = '{1'b0, 24'h000000, 1'b0, 16'h0000, 1'b1, 1'b1, 24'h000000, 1'b1, 16'h1234, 24'hfffffe};
        tbl[15] = '{1'b0, 24'h000000, 1'b0, 16'h0000, 1'b0, 1'b1, 24'h000000, 1'b0, 16'h0000, 24'h000000};

        rst_n      = 1'b0;
        flush      = 1'b0;
        flush_pc   = 24'h0;
        bus_ack    = 1'b0;
        bus_data   = 16'h0;
        inst_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset_state");
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            if (tbl[i].vld) begin
                chk($sformatf("vec%0d", i),
                    {bus_req, bus_addr, inst_valid, inst, inst_pc},
                    {tbl[i].req, tbl[i].addr, tbl[i].vld, tbl[i].ins, tbl[i].ipc});
            end else begin
                chk($sformatf("vec%0d", i), {bus_req, bus_addr, inst_valid},
                    {tbl[i].req, tbl[i].addr, tbl[i].vld});
            end
            flush      = tbl[i].fl;
            flush_pc   = tbl[i].fpc;
            bus_ack    = tbl[i].ack;
            bus_data   = tbl[i].data;
            inst_ready = tbl[i].rdy;
            @(negedge clk);
        end

        // Streaming: memory acks every request with data = addr[15:0]
        flush    = 1'b1;
        flush_pc = 24'h000100;
        bus_ack  = 1'b0;
        @(negedge clk);
        flush  = 1'b0;
        pops   = 0;
        exp_pc = 24'h000100;
        for (int c = 0; c < 40; c++) begin
            bus_ack    = bus_req;
            bus_data   = bus_addr[15:0];
            inst_ready = (c >= 4);
            if (inst_valid && inst_ready) begin
                chk($sformatf("stream_word%0d", pops), {inst_pc, inst}, {exp_pc, exp_pc[15:0]});
                exp_pc = exp_pc + 24'd2;
                pops++;
            end
            @(negedge clk);
        end
        chk("stream_pop_count", 96'(pops), 96'd36);

        // Reset asserted mid-operation with two words queued
        bus_ack    = 1'b0;
        inst_ready = 1'b0;
        flush      = 1'b1;
        flush_pc   = 24'h000300;
        @(negedge clk);
        flush    = 1'b0;
        bus_ack  = 1'b1;
        bus_data = 16'haaaa;
        @(negedge clk);
        bus_data = 16'hbbbb;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("pre_reset", {bus_req, inst_valid, inst, inst_pc, bus_addr},
            {1'b1, 1'b1, 16'haaaa, 24'h000300, 24'h000304});
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_reset");
        @(negedge clk);
        chk_reset_vals("reset_held");
        rst_n = 1'b1;
        @(negedge clk);
        chk("restart_req", {bus_req, bus_addr}, {1'b1, RstPc});

        // Odd redirect target
        flush    = 1'b1;
        flush_pc = 24'h000101;
        @(negedge clk);
        flush = 1'b0;
`ifdef PREFETCH_ADDR_CHK_EN
        chk("odd_flush", {addr_err, bus_req, inst_valid}, {1'b1, 1'b0, 1'b0});
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("halt_hold%0d", c), {addr_err, bus_req}, {1'b1, 1'b0});
        end
`else
        chk("odd_flush", {addr_err, bus_req, inst_valid, bus_addr},
            {1'b0, 1'b1, 1'b0, 24'h000100});
`endif
        flush    = 1'b1;
        flush_pc = 24'h000200;
        @(negedge clk);
        flush = 1'b0;
        chk("even_flush", {addr_err, bus_req, bus_addr}, {1'b0, 1'b1, 24'h000200});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
